// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers 8-bit samples from a 256-cycle-frame PWM stream.
// The input is synchronized, frame alignment is tracked by a phase counter,
// high cycles are accumulated per frame and published with a one-cycle strobe.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_UNLOCKED | no alignment; waiting for a rising edge to start a frame
//   ST_ACQUIRE  | aligned to a candidate rise; first frame not yet verified
//   ST_LOCKED   | alignment confirmed; counter flywheels across empty frames
//
// SYNC_STAGES must be at least 2.
module pwm_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       pwm_i,
  output logic [7:0] sample_o,
  output logic       sample_valid,
  output logic       locked,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_q;
  logic                   rise;

  logic [7:0] phase_q, phase_d;
  logic [7:0] hi_cnt_q, hi_cnt_d;
  logic [7:0] sample_q, sample_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_q;

  // Synchronizer chain plus one-cycle delay for edge detection.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      pwm_q  <= pwm_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame counter, accumulator and published-sample registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase_q  <= 8'd0;
      hi_cnt_q <= 8'd0;
      sample_q <= 8'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hi_cnt_q <= hi_cnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath decisions. A rise cycle is phase 0 and already
  // counts as one high cycle, so realignment jumps straight to phase 1.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    hi_cnt_d = hi_cnt_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_UNLOCKED: begin
        if (rise) begin
          state_d  = ST_ACQUIRE;
          phase_d  = 8'd1;
          hi_cnt_d = 8'd1;
        end
      end

      ST_ACQUIRE, ST_LOCKED: begin
        phase_d = phase_q + 8'd1;
        if (rise && (phase_q != 8'd0)) begin
          // Mid-frame rise (including at phase 255): realign, drop the frame.
          err_d    = 1'b1;
          state_d  = ST_ACQUIRE;
          phase_d  = 8'd1;
          hi_cnt_d = 8'd1;
        end else if (phase_q == 8'd255) begin
          if (pwm_s) begin
            err_d    = 1'b1;
            state_d  = ST_UNLOCKED;
            phase_d  = 8'd0;
            hi_cnt_d = 8'd0;
          end else begin
            sample_d = hi_cnt_q;
            valid_d  = 1'b1;
            state_d  = ST_LOCKED;
          end
        end else if (phase_q == 8'd0) begin
          // Only reachable while locked; a missing rise here is a zero sample.
          hi_cnt_d = {7'd0, pwm_s};
        end else begin
          hi_cnt_d = hi_cnt_q + {7'd0, pwm_s};
        end
      end

      default: begin
        state_d  = ST_UNLOCKED;
        phase_d  = 8'd0;
        hi_cnt_d = 8'd0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    locked       = (state_q == ST_LOCKED);
    sample_o     = sample_q;
    sample_valid = valid_q;
    frame_err    = err_q;
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: a frame generator drives pwm_i one cycle
// at a time, observations are taken 1 time unit after each rising edge.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       nRst;
  logic       pwm_i;
  logic [7:0] sample_o;
  logic       sample_valid;
  logic       locked;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int   vq[$];
  int   vcyc[$];
  int   ecyc[$];
  int   lock_rise_cyc;
  int   lock_falls;
  int   lock_fall_cyc;
  int   both_hi;
  logic prev_locked;

  int c0;
  int ci;
  int bad;

  pwm_decoder #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .pwm_i        (pwm_i),
    .sample_o     (sample_o),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    vq.delete();
    vcyc.delete();
    ecyc.delete();
    lock_rise_cyc = -1;
    lock_falls    = 0;
    lock_fall_cyc = -1;
    both_hi       = 0;
    prev_locked   = locked;
  endtask

  // One clock: observe the outputs updated by this edge, then drive pwm_i.
  task automatic step(input logic v);
    @(posedge clk);
    #1;
    cyc++;
    if (sample_valid) begin
      vq.push_back(int'(sample_o));
      vcyc.push_back(cyc);
    end
    if (frame_err) ecyc.push_back(cyc);
    if (sample_valid && frame_err) both_hi++;
    if (locked && !prev_locked && lock_rise_cyc < 0) lock_rise_cyc = cyc;
    if (!locked && prev_locked) begin
      lock_falls++;
      lock_fall_cyc = cyc;
    end
    prev_locked = locked;
    pwm_i = v;
  endtask

  task automatic send_frame(input int val, input int n = 256);
    for (int p = 0; p < n; p++) step(p < val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset();
    nRst  = 1'b0;
    pwm_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nRst = 1'b1;
    clear_mon();
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check_val({tag, "_count"}, vq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check_val($sformatf("%s_%0d", tag, i), (i < vq.size()) ? vq[i] : -1, exp[i]);
    end
  endtask

  task automatic check_spacing(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 1; i < vcyc.size(); i++) begin
      if (vcyc[i] - vcyc[i-1] != 256) nbad++;
    end
    check_val(tag, nbad, 0);
  endtask

  initial begin
    nRst  = 1'b0;
    pwm_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_sample_o", int'(sample_o), 0);
    check_val("rst_valid", int'(sample_valid), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_frame_err", int'(frame_err), 0);
    nRst = 1'b1;
    clear_mon();

    // Constant low from reset never locks.
    idle(600);
    check_val("low_locked", int'(locked), 0);
    check_val("low_valids", vq.size(), 0);
    check_val("low_errs", ecyc.size(), 0);

    // Continuous 128: lock 2 sync + 256 cycles after the first drive.
    do_reset();
    c0 = cyc + 1;
    repeat (6) send_frame(128);
    idle(5);
    check_val("s128_lock_latency", lock_rise_cyc - c0, 258);
    check_val("s128_first_valid", (vcyc.size() > 0) ? vcyc[0] - c0 : -1, 258);
    check_seq("s128", '{128, 128, 128, 128, 128, 128});
    check_spacing("s128_spacing");
    check_val("s128_errs", ecyc.size(), 0);
    check_val("s128_locked", int'(locked), 1);
    check_val("s128_both_hi", both_hi, 0);

    // Boundary counts and frame-by-frame changes.
    do_reset();
    send_frame(1);
    send_frame(255);
    send_frame(200);
    send_frame(3);
    idle(5);
    check_seq("seq", '{1, 255, 200, 3});
    check_val("seq_errs", ecyc.size(), 0);

    // Zero frames while locked are legal zero samples.
    do_reset();
    send_frame(77);
    repeat (4) send_frame(0);
    send_frame(77);
    idle(5);
    check_seq("zero", '{77, 0, 0, 0, 0, 77});
    check_val("zero_errs", ecyc.size(), 0);
    check_val("zero_lock_falls", lock_falls, 0);
    check_val("zero_locked", int'(locked), 1);

    // Extra rise at phase 100 while locked on 50.
    do_reset();
    send_frame(50);
    send_frame(50);
    send_frame(50, 100);
    ci = cyc + 1;
    send_frame(50);
    send_frame(50);
    idle(5);
    check_seq("inj", '{50, 50, 50, 50});
    check_val("inj_err_count", ecyc.size(), 1);
    check_val("inj_err_time", (ecyc.size() > 0) ? ecyc[0] - ci : -1, 3);
    check_val("inj_lock_falls", lock_falls, 1);
    check_val("inj_lock_fall_time", lock_fall_cyc - ci, 3);
    check_val("inj_next_valid", (vcyc.size() > 2) ? vcyc[2] - ci : -1, 258);
    check_val("inj_locked", int'(locked), 1);
    check_val("inj_both_hi", both_hi, 0);

    // Input stuck high: one framing error at phase 255, never locks.
    do_reset();
    c0 = cyc + 1;
    repeat (600) step(1'b1);
    idle(300);
    check_val("high_err_count", ecyc.size(), 1);
    check_val("high_err_time", (ecyc.size() > 0) ? ecyc[0] - c0 : -1, 258);
    check_val("high_valids", vq.size(), 0);
    check_val("high_locked", int'(locked), 0);

    // Reset mid-frame while locked, then re-acquire.
    do_reset();
    send_frame(200);
    send_frame(200);
    send_frame(200, 130);
    check_val("mrst_pre_locked", int'(locked), 1);
    check_val("mrst_pre_sample", int'(sample_o), 200);
    pwm_i = 1'b0;
    nRst  = 1'b0;
    #1;
    check_val("mrst_sample_o", int'(sample_o), 0);
    check_val("mrst_valid", int'(sample_valid), 0);
    check_val("mrst_locked", int'(locked), 0);
    check_val("mrst_frame_err", int'(frame_err), 0);
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b1;
    clear_mon();
    send_frame(33);
    send_frame(33);
    idle(5);
    check_seq("relock", '{33, 33});
    check_val("relock_sample_o", int'(sample_o), 33);
    check_val("relock_locked", int'(locked), 1);
    check_val("relock_errs", ecyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
